// File: rtl/lcd_host_drv.sv
`default_nettype none
// ============================================================================
// Module      : lcd_host_drv
// Description : Host-side driver for an LCD image controller. It queues
//               commands, streams image bytes after a load command and
//               registers returned result bytes with frame tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_host_drv #(
    parameter int N_PIX      = 36,
    parameter int OUT_N      = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       img_we,
    input  logic [5:0] img_addr,
    input  logic [7:0] img_wdata,
    output logic       img_ready,
    input  logic [2:0] cmd_in,
    input  logic       cmd_in_valid,
    output logic       cmd_in_ready,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] datain,
    input  logic       busy,
    input  logic [7:0] dataout,
    input  logic       output_valid,
    output logic [7:0] res_data,
    output logic       res_valid,
    output logic       frame_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = (OUT_N > 1) ? $clog2(OUT_N) : 1;

    localparam logic [AW:0]   c_depth    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [6:0]    c_n_pix    = 7'(N_PIX);
    localparam logic [5:0]    c_last_pix = 6'(N_PIX - 1);
    localparam logic [RW-1:0] c_last_res = RW'(OUT_N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        LOAD = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_pop;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [2:0]    r_fifo [FIFO_DEPTH];
    logic [7:0]    r_img  [N_PIX];
    logic [5:0]    r_pix_cnt;
    logic [RW-1:0] r_res_idx;
    logic [2:0]    r_cmd;
    logic          r_cmd_valid;
    logic [7:0]    r_res_data;
    logic          r_res_valid;
    logic          r_frame_done;

    // Image memory is deliberately left out of reset so a reset keeps the picture.
    always_ff @(posedge clk) begin
        if (img_we && img_ready && ({1'b0, img_addr} < c_n_pix))
            r_img[img_addr] <= img_wdata;
    end

    assign img_ready = (r_state != LOAD);

    // Full is judged on the pre-pop occupancy, so a full queue never accepts.
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = ((r_wr_ptr - r_rd_ptr) == c_depth);
    assign cmd_in_ready = ~w_full;
    assign w_push       = cmd_in_valid & ~w_full;

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr[AW-1:0]] <= cmd_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !busy) begin
                    w_pop  = 1'b1;
                    w_next = SEND;
                end
            end
            SEND:    w_next = (r_cmd == 3'd1) ? LOAD : HOLD;
            LOAD:    if (r_pix_cnt == c_last_pix) w_next = HOLD;
            HOLD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd       <= 3'd0;
            r_cmd_valid <= 1'b0;
            r_pix_cnt   <= 6'd0;
        end else begin
            r_cmd_valid <= w_pop;
            if (w_pop)
                r_cmd <= r_fifo[r_rd_ptr[AW-1:0]];
            if (r_state == LOAD && r_pix_cnt != c_last_pix)
                r_pix_cnt <= r_pix_cnt + 6'd1;
            else
                r_pix_cnt <= 6'd0;
        end
    end

    assign cmd       = r_cmd;
    assign cmd_valid = r_cmd_valid;
    // Decoded from the state register so an asynchronous reset silences the stream at once.
    assign datain    = (r_state == LOAD) ? r_img[r_pix_cnt] : 8'h00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_res_data   <= 8'h00;
            r_res_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_res_idx    <= '0;
        end else begin
            r_res_data   <= dataout;
            r_res_valid  <= output_valid;
            r_frame_done <= output_valid && (r_res_idx == c_last_res);
            // A newly issued command restarts frame counting.
            if (w_pop)
                r_res_idx <= '0;
            else if (output_valid)
                r_res_idx <= (r_res_idx == c_last_res) ? '0 : r_res_idx + 1'b1;
        end
    end

    assign res_data   = r_res_data;
    assign res_valid  = r_res_valid;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_lcd_host_drv.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_host_drv
// Description : Directed self-checking bench for lcd_host_drv.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_host_drv;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       img_we = 1'b0;
    logic [5:0] img_addr = 6'd0;
    logic [7:0] img_wdata = 8'h00;
    logic       img_ready;
    logic [2:0] cmd_in = 3'd0;
    logic       cmd_in_valid = 1'b0;
    logic       cmd_in_ready;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic [7:0] datain;
    logic       busy = 1'b0;
    logic [7:0] dataout = 8'h00;
    logic       output_valid = 1'b0;
    logic [7:0] res_data;
    logic       res_valid;
    logic       frame_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       ov;
        logic [7:0] din;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_fd;
    } res_vec_t;

    lcd_host_drv dut (
        .clk          (clk),
        .reset        (reset),
        .img_we       (img_we),
        .img_addr     (img_addr),
        .img_wdata    (img_wdata),
        .img_ready    (img_ready),
        .cmd_in       (cmd_in),
        .cmd_in_valid (cmd_in_valid),
        .cmd_in_ready (cmd_in_ready),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .datain       (datain),
        .busy         (busy),
        .dataout      (dataout),
        .output_valid (output_valid),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] c);
        cmd_in       = c;
        cmd_in_valid = 1'b1;
        tick();
        cmd_in_valid = 1'b0;
    endtask

    task automatic wait_strobe(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cmd_valid) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_strobe"}, 32'(got), 32'd1);
    endtask

    // Expects the strobe cycle to be current; checks 36 image bytes then quiet datain.
    task automatic check_stream(input string tag, input bit inject);
        for (int i = 0; i < 36; i++) begin
            tick();
            check($sformatf("%s_px%0d", tag, i), 32'(datain), 32'(i));
            if (i == 0)
                check({tag, "_cmdvalid_drop"}, 32'(cmd_valid), 32'd0);
            if (inject && i == 4) begin
                check({tag, "_img_ready_load"}, 32'(img_ready), 32'd0);
                img_we    = 1'b1;
                img_addr  = 6'd3;
                img_wdata = 8'hAA;
            end
            if (i == 5)
                img_we = 1'b0;
        end
        tick();
        check({tag, "_datain_after"}, 32'(datain), 32'd0);
        check({tag, "_img_ready_after"}, 32'(img_ready), 32'd1);
    endtask

    initial begin
        res_vec_t   vecs [13];
        logic [2:0] codes [5];
        int         gap;
        logic       any;

        vecs = '{
            '{1'b1, 8'd10, 1'b1, 8'd10, 1'b0},
            '{1'b1, 8'd11, 1'b1, 8'd11, 1'b0},
            '{1'b1, 8'd12, 1'b1, 8'd12, 1'b0},
            '{1'b0, 8'd00, 1'b0, 8'd00, 1'b0},
            '{1'b1, 8'd13, 1'b1, 8'd13, 1'b0},
            '{1'b1, 8'd14, 1'b1, 8'd14, 1'b0},
            '{1'b1, 8'd15, 1'b1, 8'd15, 1'b0},
            '{1'b1, 8'd16, 1'b1, 8'd16, 1'b0},
            '{1'b1, 8'd17, 1'b1, 8'd17, 1'b0},
            '{1'b1, 8'd18, 1'b1, 8'd18, 1'b1},
            '{1'b0, 8'd00, 1'b0, 8'd00, 1'b0},
            '{1'b1, 8'd20, 1'b1, 8'd20, 1'b0},
            '{1'b0, 8'd00, 1'b0, 8'd00, 1'b0}
        };
        codes = '{3'd2, 3'd4, 3'd5, 3'd6, 3'd7};

        // Reset state
        repeat (3) tick();
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_datain", 32'(datain), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_cmd_in_ready", 32'(cmd_in_ready), 32'd1);
        check("rst_img_ready", 32'(img_ready), 32'd1);
        reset = 1'b1;
        tick();

        // Result path: one-cycle latency, frame_done on the 9th byte, then wrap
        for (int i = 0; i < 13; i++) begin
            output_valid = vecs[i].ov;
            dataout      = vecs[i].din;
            tick();
            check($sformatf("res_valid_v%0d", i), 32'(res_valid), 32'(vecs[i].exp_valid));
            check($sformatf("res_data_v%0d", i), 32'(res_data), 32'(vecs[i].exp_data));
            check($sformatf("frame_done_v%0d", i), 32'(frame_done), 32'(vecs[i].exp_fd));
        end
        output_valid = 1'b0;
        dataout      = 8'h00;

        // Fill image memory with img[i]=i plus one out-of-range write
        for (int i = 0; i < 36; i++) begin
            img_we    = 1'b1;
            img_addr  = 6'(i);
            img_wdata = 8'(i);
            tick();
        end
        img_addr  = 6'd40;
        img_wdata = 8'hFF;
        tick();
        img_we = 1'b0;

        // Load command streams the image; a write during LOAD is ignored
        push(3'd1);
        wait_strobe("load1");
        check("load1_cmd", 32'(cmd), 32'd1);
        check_stream("load1", 1'b1);

        // busy holds issue; released commands come 3 cycles apart
        tick();
        busy = 1'b1;
        push(3'd2);
        push(3'd3);
        any = 1'b0;
        repeat (5) begin
            tick();
            any |= cmd_valid;
        end
        check("busy_no_strobe", 32'(any), 32'd0);
        busy = 1'b0;
        wait_strobe("busy_first");
        check("busy_first_cmd", 32'(cmd), 32'd2);
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            gap++;
            if (cmd_valid) break;
        end
        check("busy_gap", 32'(gap), 32'd3);
        check("busy_second_cmd", 32'(cmd), 32'd3);
        repeat (3) tick();

        // Queue fills at four entries; the fifth push is refused
        busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("fifo_ready_before_push%0d", k), 32'(cmd_in_ready), (k < 4) ? 32'd1 : 32'd0);
            cmd_in       = codes[k];
            cmd_in_valid = 1'b1;
            tick();
        end
        cmd_in_valid = 1'b0;
        check("fifo_full_ready", 32'(cmd_in_ready), 32'd0);
        busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_strobe($sformatf("fifo_issue%0d", k));
            check($sformatf("fifo_cmd%0d", k), 32'(cmd), 32'(codes[k]));
        end
        any = 1'b0;
        repeat (8) begin
            tick();
            any |= cmd_valid;
        end
        check("fifo_no_fifth", 32'(any), 32'd0);
        check("fifo_ready_drained", 32'(cmd_in_ready), 32'd1);

        // Reset on the 10th LOAD cycle aborts the stream
        push(3'd1);
        wait_strobe("abort");
        check("abort_cmd", 32'(cmd), 32'd1);
        repeat (9) tick();
        check("abort_px8", 32'(datain), 32'd8);
        output_valid = 1'b1;
        dataout      = 8'h55;
        tick();
        output_valid = 1'b0;
        check("abort_px9", 32'(datain), 32'd9);
        check("abort_res_valid_pre", 32'(res_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_cmd_zero", 32'(cmd), 32'd0);
        check("abort_cmd_valid_zero", 32'(cmd_valid), 32'd0);
        check("abort_datain_zero", 32'(datain), 32'd0);
        check("abort_res_valid_zero", 32'(res_valid), 32'd0);
        check("abort_res_data_zero", 32'(res_data), 32'd0);
        check("abort_frame_done_zero", 32'(frame_done), 32'd0);
        check("abort_img_ready", 32'(img_ready), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        any = 1'b0;
        repeat (6) begin
            tick();
            any |= (datain != 8'h00) | cmd_valid;
        end
        check("abort_quiet", 32'(any), 32'd0);

        // Memory survived reset and the ignored LOAD-time write
        push(3'd1);
        wait_strobe("reload");
        check("reload_cmd", 32'(cmd), 32'd1);
        check_stream("reload", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
